// File: rtl/encoder_8_3.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags.
// Outputs come straight from flops; reset release is synchronized to clk.
module encoder_8_3 #(
  parameter bit MSB_PRIORITY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] a,
  output logic [2:0] y,
  output logic       valid,
  output logic       multi
);

  typedef struct packed {
    logic [2:0] y;
    logic       valid;
    logic       multi;
  } enc_rsp_t;

  logic [1:0] rst_sync;
  enc_rsp_t   rsp_d, rsp_q;

  // Assert asynchronously, release two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  always_comb begin
    rsp_d       = '0;
    rsp_d.valid = |a;
    rsp_d.multi = (|a) & (|(a & (a - 8'd1)));
    // Later loop iterations overwrite earlier ones, so scan order sets priority.
    if (MSB_PRIORITY) begin
      for (int i = 0; i < 8; i++)
        if (a[i]) rsp_d.y = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (a[i]) rsp_d.y = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            rsp_q <= '0;
    else if (!rst_sync[1]) rsp_q <= '0;
    else                   rsp_q <= rsp_d;
  end

  assign y     = rsp_q.y;
  assign valid = rsp_q.valid;
  assign multi = rsp_q.multi;

endmodule

// File: tb/tb_encoder_8_3.sv
// Bench for encoder_8_3: both priority settings driven from one request bus,
// compared against an arithmetic reference model.
module tb_encoder_8_3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a = 8'h00;
  logic [2:0] y_m, y_l;
  logic       valid_m, valid_l, multi_m, multi_l;

  int n_chk = 0;
  int n_pass = 0;

  encoder_8_3 #(.MSB_PRIORITY(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y_m), .valid(valid_m), .multi(multi_m));
  encoder_8_3 #(.MSB_PRIORITY(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .a(a), .y(y_l), .valid(valid_l), .multi(multi_l));

  always #5 clk = ~clk;

  // Expected {y, valid, multi} from popcount and log2 arithmetic.
  function automatic logic [4:0] model(input logic [7:0] v, input bit msb);
    int x, lo;
    logic [2:0] idx;
    x = int'(v);
    idx = 3'd0;
    if (x != 0) begin
      if (msb) idx = 3'($clog2(x + 1) - 1);
      else begin
        lo  = x & (-x);
        idx = 3'($clog2(lo));
      end
    end
    return {idx, (x != 0), ($countones(v) >= 2)};
  endfunction

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got y/valid/multi=%0d/%0b/%0b expected %0d/%0b/%0b",
                  tag, got[4:2], got[1], got[0], exp[4:2], exp[1], exp[0]);
  endtask

  task automatic chk_both(input string tag, input logic [7:0] v);
    chk({tag, "_msb"}, {y_m, valid_m, multi_m}, model(v, 1'b1));
    chk({tag, "_lsb"}, {y_l, valid_l, multi_l}, model(v, 1'b0));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_msb"}, {y_m, valid_m, multi_m}, 5'b0);
    chk({tag, "_lsb"}, {y_l, valid_l, multi_l}, 5'b0);
  endtask

  task automatic step(input string tag, input logic [7:0] v);
    @(negedge clk);
    a = v;
    @(posedge clk);
    #1;
    chk_both(tag, v);
  endtask

  // Release at a falling edge: two edges of synchronizer, third edge loads.
  task automatic release_and_check(input string tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1; chk_zero({tag, "_sync1"});
    @(posedge clk); #1; chk_zero({tag, "_sync2"});
    @(posedge clk); #1; chk_both({tag, "_first"}, a);
  endtask

  logic [7:0] mh [4] = '{8'b00010001, 8'b00101010, 8'b11100000, 8'b01111111};
  logic [7:0] v;

  initial begin
    // Reset held with all requests active.
    a = 8'hFF;
    #1 chk_zero("rst_async");
    repeat (3) begin
      @(posedge clk); #1; chk_zero("rst_hold");
    end
    release_and_check("rst_rel");
    chk("rst_rel_y7", {y_m, valid_m, multi_m}, {3'd7, 1'b1, 1'b1});

    step("zero", 8'h00);

    for (int i = 0; i < 8; i++) begin
      v = 8'b1 << i;
      step("onehot", v);
      chk("onehot_idx", {y_m, valid_m, multi_m}, {3'(i), 1'b1, 1'b0});
    end

    for (int i = 0; i < 4; i++) step("multihot", mh[i]);

    // Back-to-back random vectors, zero injected now and then.
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      step("rand", v);
    end

    // Mid-stream reset pulse between edges.
    step("pre_rst", 8'b01000000);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_rst_async");
    a = 8'($urandom) | 8'h01;
    @(posedge clk); #1; chk_zero("mid_rst_hold");
    release_and_check("mid_rel");
    for (int i = 0; i < 20; i++) step("post_rst", 8'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/encoder_8_3.md
# encoder_8_3

Registered 8-to-3 priority encoder. Converts an 8-bit request vector into the 3-bit index of its highest-priority set bit, with a valid flag and a multi-hot flag. Serves as a synchronous arbitration/index front end wherever a one-hot or multi-hot request bus must be reduced to a binary index. Outputs are registered, one cycle after input sampling.

## Interface

Parameters:
- MSB_PRIORITY, default 1: 1 = highest-numbered set bit wins; 0 = lowest-numbered set bit wins.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- a  input  8  request vector; bit i set = request from source i.
- y  output  3  binary index of the winning request bit.
- valid  output  1  1 when at least one bit of the sampled `a` was set.
- multi  output  1  1 when two or more bits of the sampled `a` were set.

## Operation

- Combinational stage, evaluated on the current `a`:
  - Any-set: OR of all 8 bits of `a`.
  - Winner selection:
    - MSB_PRIORITY=1: index of the highest set bit. 8'b10000000 gives 7 and 8'b00000001 gives 0.
    - MSB_PRIORITY=0: index of the lowest set bit.
  - Multi-hot: 1 when the population count of `a` is 2 or more. Implement as any-set AND (`a` AND (`a`−1)) ≠ 0, or an equivalent expression.
  - `a` = 0: next `y` = 3'd0, next valid = 0, next multi = 0.
- Register stage:
  - Every rising clk edge loads `y`, `valid` and `multi` from the combinational stage.
  - There is no enable and no hold. The block accepts a new vector every cycle.
- Single-hot inputs: `y` = bit position, valid = 1, multi = 0. Result is the same for both parameter values.
- `y` is meaningful only while valid = 1. It is defined as 0 when valid = 0.
- Inputs containing X or Z are not supported. Behavior for such inputs is outside the contract.

## Timing

- Latency: exactly 1 clock.
  - `a` sampled at edge N appears on `y`, `valid` and `multi` after edge N.
  - Outputs stay stable until edge N+1.
- Throughput: 1 vector per clock. Back-to-back changes are each reflected on consecutive cycles.
- Reset:
  - rst_n low forces `y` = 3'd0, `valid` = 0, `multi` = 0 immediately, with no clock needed.
  - Outputs hold those values while rst_n is low.
- Reset release:
  - Deassertion is synchronized internally to clk through a 2-flop synchronizer.
  - The first output update happens on the first rising edge after the synchronized release.
  - Edges before that leave outputs at reset values.
- Reset asserted mid-stream: any in-flight result is discarded. There is no residual state after release.
- Outputs are glitch-free between edges because they are driven directly from flops.
- Combinational depth from `a` to the flop D inputs fits in a single cycle. There is no multicycle path.

## Test plan

1. Reset: hold rst_n=0 with `a`=8'hFF and toggle clk.
   - Required: y=0, valid=0, multi=0 throughout.
   - After release and synchronizer delay: y=7, valid=1, multi=1.
2. Zero input: `a`=8'b00000000 → one cycle later y=0, valid=0, multi=0.
3. Single-hot sweep: `a`=8'b00000001, 00000010, 00000100 … 10000000, one per cycle, MSB_PRIORITY=1.
   - Required: y = 0,1,2…7 on successive cycles, each one cycle after its input.
   - valid=1 and multi=0 for every step.
4. Multi-hot, MSB_PRIORITY=1:
   - 8'b00010001 → y=4.
   - 8'b00101010 → y=5.
   - 8'b11100000 → y=7.
   - 8'b01111111 → y=6.
   - Each with valid=1 and multi=1.
5. Multi-hot, MSB_PRIORITY=0, same vectors:
   - 00010001 → y=0.
   - 00101010 → y=1.
   - 11100000 → y=5.
   - 01111111 → y=0.
   - Each with valid=1 and multi=1.
6. Mid-stream reset: drive 8'b01000000 (y=6), then pulse rst_n low between edges.
   - Required: y drops to 0 and valid to 0 asynchronously.
   - After release and synchronization, y tracks the current `a` again with 1-cycle latency.
